sdh_tx_frame_ctrl: RTL and testbench
====================================

# sdh_tx_frame_ctrl

Transmit-side frame sequencer for the STM-1 byte-wide path in the `sdh_clk` domain. It tracks the row/column position of every transmitted byte and marks the section-overhead positions (A1, A2, J0, B1). It also drives the scrambler enable/reset and produces the `start_of_frame` / `start_of_frame_d1` strobes that the B1 parity accumulator uses. It sits between the transmit enable logic and the overhead-insertion mux, scrambler and B1 calculator.

## Interface
- `COLS`, 270, columns per row.
- `ROWS`, 9, rows per frame.
- `OH_COLS`, 9, section-overhead columns at the start of each row.
- `rst_n`  in  1  asynchronous active-low reset.
- `sdh_clk`  in  1  byte clock; all state changes on its rising edge.
- `tx_en`  in  1  level request to transmit frames.
- `row_cnt`  out  4  current row, 0..`ROWS`-1.
- `col_cnt`  out  9  current column, 0..`COLS`-1.
- `start_of_frame`  out  1  high for the byte at (0,0).
- `start_of_frame_d1`  out  1  `start_of_frame` delayed one cycle, aligned to the scrambler output.
- `oh_sel`  out  3  byte-type code: 0 payload, 1 A1, 2 A2, 3 J0, 4 B1, 5 other SOH.
- `scram_en`  out  1  scrambler advance/apply enable.
- `scram_rst`  out  1  scrambler preset-to-all-ones pulse.
- `b1_valid`  out  1  the B1 value from the previous frame is meaningful.
- `frame_cnt`  out  8  frames started since leaving IDLE; wraps modulo 256.
- `busy`  out  1  high in RUN or DRAIN.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- Reset value of every output is 0. The FSM resets to IDLE.
- IDLE:
  - Counters are held at (0,0) and all outputs are 0.
  - `tx_en`=1 moves the FSM to RUN. The first RUN cycle presents position (0,0) with `start_of_frame`=1.
- RUN:
  - Each cycle `col_cnt` increments. At `COLS`-1 it wraps to 0 and `row_cnt` increments.
  - At (`ROWS`-1,`COLS`-1) both counters wrap to (0,0).
  - `frame_cnt` increments on every (0,0) after the first one.
  - If `tx_en`=0, the FSM moves to DRAIN and counting continues.
- DRAIN:
  - Counting continues as in RUN.
  - `tx_en`=1 returns the FSM to RUN with no discontinuity.
  - The last byte (`ROWS`-1,`COLS`-1) moves the FSM to IDLE on the next edge. No partial frame is ever emitted.
- `oh_sel` decode (applies in RUN/DRAIN only):
  - Row 0, cols 0-2 → A1.
  - Row 0, cols 3-5 → A2.
  - Row 0, col 6 → J0.
  - Row 1, col 0 → B1.
  - Any other col < `OH_COLS` → other SOH.
  - Otherwise → payload.
- Scrambler control:
  - `scram_en`=0 for row 0, cols 0..`OH_COLS`-1; `scram_en`=1 for every other byte in RUN/DRAIN.
  - `scram_rst`=1 only at row 0, col `OH_COLS`-1.
- `b1_valid`:
  - Cleared in IDLE.
  - Set at the first `start_of_frame_d1` after a complete frame has been emitted, i.e. from the second frame onward.
  - The insertion mux inserts 0x00 at the B1 position when `b1_valid`=0.
- Reset mid-frame: immediate return to IDLE with all outputs 0. No drain occurs.

## Timing
- All outputs are registered.
- Outputs in a given cycle describe the byte being presented in that same cycle at the insertion mux input.
- Frame length is `ROWS`×`COLS` = 2430 cycles. The B1 position is cycle offset 270 within the frame.
- `start_of_frame_d1` follows `start_of_frame` by exactly 1 cycle. It is also emitted for the final frame's (0,0) when that frame ends in DRAIN.
- Latency from IDLE is 1 cycle: if `tx_en` is sampled high on edge k, then (0,0) with `start_of_frame`=1 appears after edge k.
- When a frame boundary and a `tx_en` deassertion happen in the same cycle, the new frame still starts and drains completely.
- Counter widths are chosen so no overflow is possible. Column and row comparisons use exact equality to `COLS`-1 and `ROWS`-1.

## Test plan
- Reset, then `tx_en`=1 held → `start_of_frame` at cycles 1, 2431, 4861. `start_of_frame_d1` at cycles 2, 2432, 4862. `frame_cnt` reads 0, 1, 2.
- One full frame → `oh_sel` sequence 1,1,1,2,2,2,3,5,5 then 0×261 on row 0. Row 1 col 0 gives 4. Exactly 81 non-zero `oh_sel` bytes per frame.
- Scrambler checks → `scram_en`=0 for exactly 9 cycles per frame. `scram_rst` pulses once per frame at (0,8). `b1_valid`=0 during frame 0 and =1 from frame 1's `start_of_frame_d1` onward.
- `tx_en` dropped at (4,100) → the frame completes to (8,269), then IDLE with all outputs 0. `tx_en` re-raised at (6,0) → no gap, and the next (0,0) follows normally.
- `rst_n` asserted at (3,50) → all outputs 0 in the same cycle (asynchronous). After release with `tx_en`=1 → restart at (0,0) with `frame_cnt`=0 and `b1_valid`=0.
- Long run of 257 frames → `frame_cnt` wraps 255→0 with no effect on position counters.

Source files
------------

// File: rtl/sdh_tx_frame_ctrl.sv
// STM-1 transmit frame sequencer: tracks row/column of each byte, marks
// section-overhead positions and drives scrambler and B1 framing strobes.
module sdh_tx_frame_ctrl #(
    parameter int COLS    = 270,
    parameter int ROWS    = 9,
    parameter int OH_COLS = 9
) (
    input  logic       rst_n,
    input  logic       sdh_clk,
    input  logic       tx_en,
    output logic [3:0] row_cnt,
    output logic [8:0] col_cnt,
    output logic       start_of_frame,
    output logic       start_of_frame_d1,
    output logic [2:0] oh_sel,
    output logic       scram_en,
    output logic       scram_rst,
    output logic       b1_valid,
    output logic [7:0] frame_cnt,
    output logic       busy
);

    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [8:0] COL_LAST = 9'(COLS - 1);
    localparam logic [8:0] OH_LAST  = 9'(OH_COLS - 1);

    localparam logic [2:0] OH_PAYLOAD = 3'd0;
    localparam logic [2:0] OH_A1      = 3'd1;
    localparam logic [2:0] OH_A2      = 3'd2;
    localparam logic [2:0] OH_J0      = 3'd3;
    localparam logic [2:0] OH_B1      = 3'd4;
    localparam logic [2:0] OH_SOH     = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] w_row_nxt;
    logic [8:0] w_col_nxt;
    logic       w_last;
    logic       w_active;
    logic       w_wrap;
    logic       w_sof_nxt;
    logic [2:0] w_oh_nxt;
    logic       w_scram_en_nxt;
    logic       w_scram_rst_nxt;
    logic       w_b1_nxt;
    logic [7:0] w_frame_cnt_nxt;

    function automatic logic [2:0] f_oh_decode(input logic [3:0] row, input logic [8:0] col);
        logic [2:0] code;
        if (col > OH_LAST)                        code = OH_PAYLOAD;
        else if (row == 4'd0 && col < 9'd3)       code = OH_A1;
        else if (row == 4'd0 && col < 9'd6)       code = OH_A2;
        else if (row == 4'd0 && col == 9'd6)      code = OH_J0;
        else if (row == 4'd1 && col == 9'd0)      code = OH_B1;
        else                                      code = OH_SOH;
        return code;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = '0;
        w_col_nxt   = '0;
        w_last      = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

        case (r_state)
            IDLE: begin
                if (tx_en) w_state_nxt = RUN;
            end
            RUN: begin
                if (!tx_en) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (tx_en)       w_state_nxt = RUN;
                else if (w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Position advances in RUN/DRAIN; a frame end always wraps to (0,0).
        if (r_state != IDLE) begin
            if (col_cnt == COL_LAST) begin
                w_col_nxt = '0;
                w_row_nxt = (row_cnt == ROW_LAST) ? 4'd0 : row_cnt + 4'd1;
            end else begin
                w_col_nxt = col_cnt + 9'd1;
                w_row_nxt = row_cnt;
            end
        end

        w_active = (w_state_nxt != IDLE);
        if (!w_active) begin
            w_row_nxt = '0;
            w_col_nxt = '0;
        end

        w_wrap    = (r_state != IDLE) && w_last && w_active;
        w_sof_nxt = w_active && (w_row_nxt == 4'd0) && (w_col_nxt == 9'd0);

        w_frame_cnt_nxt = frame_cnt;
        if (!w_active || r_state == IDLE) w_frame_cnt_nxt = '0;
        else if (w_wrap)                  w_frame_cnt_nxt = frame_cnt + 8'd1;

        w_oh_nxt        = w_active ? f_oh_decode(w_row_nxt, w_col_nxt) : OH_PAYLOAD;
        w_scram_en_nxt  = w_active && !((w_row_nxt == 4'd0) && (w_col_nxt <= OH_LAST));
        w_scram_rst_nxt = w_active && (w_row_nxt == 4'd0) && (w_col_nxt == OH_LAST);

        // B1 becomes meaningful once the start of a non-first frame has passed the scrambler.
        w_b1_nxt = w_active && (b1_valid || (start_of_frame && frame_cnt != 8'd0));
    end

    always_ff @(posedge sdh_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            row_cnt           <= '0;
            col_cnt           <= '0;
            start_of_frame    <= 1'b0;
            start_of_frame_d1 <= 1'b0;
            oh_sel            <= '0;
            scram_en          <= 1'b0;
            scram_rst         <= 1'b0;
            b1_valid          <= 1'b0;
            frame_cnt         <= '0;
            busy              <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            row_cnt           <= w_row_nxt;
            col_cnt           <= w_col_nxt;
            start_of_frame    <= w_sof_nxt;
            start_of_frame_d1 <= start_of_frame;
            oh_sel            <= w_oh_nxt;
            scram_en          <= w_scram_en_nxt;
            scram_rst         <= w_scram_rst_nxt;
            b1_valid          <= w_b1_nxt;
            frame_cnt         <= w_frame_cnt_nxt;
            busy              <= w_active;
        end
    end

endmodule

// File: tb/tb_sdh_tx_frame_ctrl.sv
// Bench for sdh_tx_frame_ctrl: reference model feeds a scoreboard queue,
// plus a reduced-size instance to exercise the frame counter wrap quickly.
module tb_sdh_tx_frame_ctrl;

    localparam int COLS    = 270;
    localparam int ROWS    = 9;
    localparam int OH_COLS = 9;
    localparam int FRAME   = COLS * ROWS;
    localparam int S_COLS  = 16;
    localparam int S_ROWS  = 2;
    localparam int S_FRAME = S_COLS * S_ROWS;

    logic clk = 1'b0;
    logic rst_n;
    logic tx_en;
    logic tx_en_s;

    always #5 clk = ~clk;

    logic [3:0] row_cnt;
    logic [8:0] col_cnt;
    logic       sof, sofd1, scram_en, scram_rst, b1_valid, busy;
    logic [2:0] oh_sel;
    logic [7:0] frame_cnt;

    logic [3:0] s_row;
    logic [8:0] s_col;
    logic       s_sof, s_sofd1, s_en, s_rst, s_b1, s_busy;
    logic [2:0] s_oh;
    logic [7:0] s_fc;

    sdh_tx_frame_ctrl #(.COLS(COLS), .ROWS(ROWS), .OH_COLS(OH_COLS)) u_dut (
        .rst_n(rst_n), .sdh_clk(clk), .tx_en(tx_en),
        .row_cnt(row_cnt), .col_cnt(col_cnt),
        .start_of_frame(sof), .start_of_frame_d1(sofd1),
        .oh_sel(oh_sel), .scram_en(scram_en), .scram_rst(scram_rst),
        .b1_valid(b1_valid), .frame_cnt(frame_cnt), .busy(busy)
    );

    sdh_tx_frame_ctrl #(.COLS(S_COLS), .ROWS(S_ROWS), .OH_COLS(OH_COLS)) u_small (
        .rst_n(rst_n), .sdh_clk(clk), .tx_en(tx_en_s),
        .row_cnt(s_row), .col_cnt(s_col),
        .start_of_frame(s_sof), .start_of_frame_d1(s_sofd1),
        .oh_sel(s_oh), .scram_en(s_en), .scram_rst(s_rst),
        .b1_valid(s_b1), .frame_cnt(s_fc), .busy(s_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [29:0] sb_q[$];
    logic [29:0] e;

    // reference model state
    bit m_act, m_drain, m_b1, m_sofd1;
    int m_p, m_fc, m_done;

    function automatic logic [29:0] obs_vec();
        return {row_cnt, col_cnt, sof, sofd1, oh_sel, scram_en, scram_rst, b1_valid, frame_cnt, busy};
    endfunction

    function automatic logic [29:0] exp_vec();
        int r, c;
        logic [2:0] oh;
        logic en, rs, s;
        r  = m_p / COLS;
        c  = m_p % COLS;
        oh = 3'd0;
        if (c < OH_COLS) begin
            if (r == 0 && c < 3)       oh = 3'd1;
            else if (r == 0 && c < 6)  oh = 3'd2;
            else if (r == 0 && c == 6) oh = 3'd3;
            else if (r == 1 && c == 0) oh = 3'd4;
            else                       oh = 3'd5;
        end
        en = !(r == 0 && c < OH_COLS);
        rs = (r == 0 && c == OH_COLS - 1);
        s  = (m_p == 0);
        if (!m_act)
            return {4'd0, 9'd0, 1'b0, m_sofd1, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        return {4'(r), 9'(c), s, m_sofd1, oh, en, rs, m_b1, 8'(m_fc), 1'b1};
    endfunction

    task automatic model_clear();
        m_act = 0; m_drain = 0; m_b1 = 0; m_sofd1 = 0;
        m_p = 0; m_fc = 0; m_done = 0;
        sb_q.delete();
    endtask

    // Steps the model on the current tx_en, queues the expectation, then clocks the DUT.
    task automatic advance();
        bit prev_sof, last;
        prev_sof = m_act && (m_p == 0);
        if (!m_act) begin
            if (tx_en) begin
                m_act = 1; m_drain = 0; m_p = 0; m_fc = 0; m_done = 0; m_b1 = 0;
            end
        end else begin
            last = (m_p == FRAME - 1);
            if (m_drain && !tx_en && last) begin
                m_act = 0; m_p = 0; m_fc = 0; m_done = 0; m_b1 = 0;
            end else begin
                m_drain = !tx_en;
                if (last) begin
                    m_p = 0; m_fc = (m_fc + 1) % 256; m_done++;
                end else begin
                    m_p++;
                end
            end
        end
        if (m_act && m_p == 1 && m_done >= 1) m_b1 = 1;
        m_sofd1 = prev_sof;
        sb_q.push_back(exp_vec());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_en = 1'b0; tx_en_s = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs_vec() !== 30'd0) begin
            bad++; $display("FAIL reset_state got=%h want=%h", obs_vec(), 30'd0);
        end
        total++;
        if (s_busy !== 1'b0 || s_fc !== 8'd0) begin
            bad++; $display("FAIL reset_small got=%b/%h want=0/00", s_busy, s_fc);
        end
        rst_n = 1'b1;
        cyc = 0;
        repeat (3) begin
            advance(); e = sb_q.pop_front(); total++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL idle_hold cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sof_q[$], d1_q[$], fc_q[$];
        int n_oh, n_en0, n_rst, guard;
        int exp_sof[3];
        int exp_d1[3];
        exp_sof = '{1, 2431, 4861};
        exp_d1  = '{2, 2432, 4862};
        n_oh = 0; n_en0 = 0; n_rst = 0;
        cyc = 0;
        tx_en = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            advance(); e = sb_q.pop_front(); total++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL b2b_seq cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
            if (sof) begin sof_q.push_back(cyc); fc_q.push_back(int'(frame_cnt)); end
            if (sofd1) d1_q.push_back(cyc);
            if (busy) begin
                if (oh_sel != 3'd0) n_oh++;
                if (!scram_en) n_en0++;
                if (scram_rst) n_rst++;
            end
            if (cyc == 2431) begin
                total++;
                if (b1_valid !== 1'b0) begin bad++; $display("FAIL b1_before got=%b want=0", b1_valid); end
            end
            if (cyc == 2432) begin
                total++;
                if (b1_valid !== 1'b1) begin bad++; $display("FAIL b1_after got=%b want=1", b1_valid); end
            end
        end
        total++;
        if (sof_q.size() != 3 || d1_q.size() != 3) begin
            bad++; $display("FAIL sof_count got=%0d/%0d want=3/3", sof_q.size(), d1_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (sof_q[k] != exp_sof[k] || d1_q[k] != exp_d1[k] || fc_q[k] != k) begin
                    bad++;
                    $display("FAIL sof_pos k=%0d got=%0d,%0d,fc%0d want=%0d,%0d,fc%0d",
                             k, sof_q[k], d1_q[k], fc_q[k], exp_sof[k], exp_d1[k], k);
                end
            end
        end
        total++;
        if (n_oh != 3 * 81) begin bad++; $display("FAIL oh_count got=%0d want=%0d", n_oh, 3 * 81); end
        total++;
        if (n_en0 != 3 * 9) begin bad++; $display("FAIL scram_en_count got=%0d want=%0d", n_en0, 3 * 9); end
        total++;
        if (n_rst != 3) begin bad++; $display("FAIL scram_rst_count got=%0d want=3", n_rst); end
        tx_en = 1'b0;
        guard = 0;
        while (m_act && guard < 3 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL b2b_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
        total++;
        if (m_act || obs_vec() !== 30'd0) begin
            bad++; $display("FAIL b2b_idle got=%h want=%h", obs_vec(), 30'd0);
        end
    endtask

    task automatic test_drain_stop();
        int guard;
        cyc = 0; guard = 0;
        tx_en = 1'b1;
        while (!(m_act && m_p == 4 * COLS + 100) && guard < 2 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL stop_run cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
        total++;
        if (row_cnt !== 4'd4 || col_cnt !== 9'd100) begin
            bad++; $display("FAIL stop_pos got=%0d,%0d want=4,100", row_cnt, col_cnt);
        end
        tx_en = 1'b0;
        guard = 0;
        while (m_act && guard < 2 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL stop_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
        repeat (3) begin
            advance(); e = sb_q.pop_front(); total++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL stop_idle cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
        total++;
        if (busy !== 1'b0 || m_act) begin bad++; $display("FAIL stop_busy got=%b want=0", busy); end
    endtask

    task automatic test_drain_resume();
        int guard, frames_seen;
        cyc = 0; guard = 0;
        tx_en = 1'b1;
        while (!(m_act && m_p == 4 * COLS + 100) && guard < 2 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL resume_run cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
        tx_en = 1'b0;
        guard = 0;
        while (!(m_p == 6 * COLS) && guard < 2 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL resume_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
        total++;
        if (row_cnt !== 4'd6 || col_cnt !== 9'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL resume_pos got=%0d,%0d,%b want=6,0,1", row_cnt, col_cnt, busy);
        end
        tx_en = 1'b1;
        frames_seen = 0;
        guard = 0;
        while (frames_seen < 1 && guard < 2 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL resume_cont cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
            if (sof) begin
                frames_seen++;
                total++;
                if (frame_cnt !== 8'd1) begin bad++; $display("FAIL resume_fc got=%0d want=1", frame_cnt); end
            end
        end
        total++;
        if (frames_seen != 1) begin bad++; $display("FAIL resume_sof got=%0d want=1", frames_seen); end
        tx_en = 1'b0;
        guard = 0;
        while (m_act && guard < 2 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL resume_end cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
        total++;
        if (obs_vec() !== 30'd0) begin bad++; $display("FAIL resume_idle got=%h want=%h", obs_vec(), 30'd0); end
    endtask

    task automatic test_boundary_drop();
        int guard, busy_cycles;
        cyc = 0; guard = 0;
        tx_en = 1'b1;
        while (!(m_act && m_p == FRAME - 1) && guard < 2 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL bnd_run cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
        tx_en = 1'b0;
        busy_cycles = 0;
        guard = 0;
        while (m_act && guard < 3 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL bnd_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
            if (busy) busy_cycles++;
        end
        total++;
        if (busy_cycles != FRAME) begin
            bad++; $display("FAIL bnd_len got=%0d want=%0d", busy_cycles, FRAME);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        cyc = 0; guard = 0;
        tx_en = 1'b1;
        while (!(m_act && m_p == 3 * COLS + 50) && guard < 2 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL ar_run cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs_vec() !== 30'd0) begin bad++; $display("FAIL ar_immediate got=%h want=%h", obs_vec(), 30'd0); end
        model_clear();
        @(posedge clk);
        #1;
        total++;
        if (obs_vec() !== 30'd0) begin bad++; $display("FAIL ar_hold got=%h want=%h", obs_vec(), 30'd0); end
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < COLS + 20; i++) begin
            advance(); e = sb_q.pop_front(); total++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL ar_restart cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
            if (cyc == 1) begin
                total++;
                if (sof !== 1'b1 || frame_cnt !== 8'd0 || row_cnt !== 4'd0 || col_cnt !== 9'd0) begin
                    bad++; $display("FAIL ar_first got=%b,%0d,%0d,%0d want=1,0,0,0", sof, frame_cnt, row_cnt, col_cnt);
                end
            end
            if (cyc == COLS + 1) begin
                total++;
                if (oh_sel !== 3'd4 || b1_valid !== 1'b0) begin
                    bad++; $display("FAIL ar_b1pos got=%0d,%b want=4,0", oh_sel, b1_valid);
                end
            end
        end
        tx_en = 1'b0;
        guard = 0;
        while (m_act && guard < 2 * FRAME) begin
            advance(); e = sb_q.pop_front(); total++; guard++;
            if (obs_vec() !== e) begin
                bad++; $display("FAIL ar_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), e);
            end
        end
    endtask

    task automatic test_frame_wrap();
        int fc_q[$];
        int want_fc, guard, n;
        bit exp_sof;
        n = 257 * S_FRAME + 2;
        tx_en_s = 1'b1;
        for (int t = 1; t <= n; t++) begin
            @(posedge clk);
            #1;
            exp_sof = ((t - 1) % S_FRAME) == 0;
            if (exp_sof) fc_q.push_back(((t - 1) / S_FRAME) % 256);
            total++;
            if (s_sof !== exp_sof || s_row !== 4'(((t - 1) / S_COLS) % S_ROWS) || s_col !== 9'((t - 1) % S_COLS)) begin
                bad++;
                $display("FAIL wrap_pos t=%0d got=%b,%0d,%0d want=%b,%0d,%0d", t, s_sof, s_row, s_col,
                         exp_sof, ((t - 1) / S_COLS) % S_ROWS, (t - 1) % S_COLS);
            end
            if (s_sof && fc_q.size() > 0) begin
                want_fc = fc_q.pop_front();
                total++;
                if (s_fc !== 8'(want_fc)) begin
                    bad++; $display("FAIL wrap_fc t=%0d got=%0d want=%0d", t, s_fc, want_fc);
                end
            end
        end
        tx_en_s = 1'b0;
        guard = 0;
        while (s_busy && guard < 2 * S_FRAME) begin
            @(posedge clk);
            #1;
            guard++;
        end
        total++;
        if (s_busy !== 1'b0 || s_fc !== 8'd0) begin
            bad++; $display("FAIL wrap_idle got=%b,%0d want=0,0", s_busy, s_fc);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_drain_stop();
        test_drain_resume();
        test_boundary_drop();
        test_async_reset();
        test_frame_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
